// File: rtl/tmc5130_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tmc5130_spi_responder
// Purpose  : TMC5130-style 40-bit SPI target with 128x32 register file and
//            pipelined read response (status byte + previous read data).
// Revision : 1.0 - initial release
// ============================================================================
module tmc5130_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        csn,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [7:0]  status_in,
    output logic        wr_stb,
    output logic [6:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        frame_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_READY  = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam logic [5:0] C_FULL_CNT = 6'd40;
    localparam logic [5:0] C_SAT_CNT  = 6'd41;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_csn_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_q;
    logic                   r_csn_q;

    logic [1:0]  r_state;
    logic [39:0] r_tx_sr;
    logic [39:0] r_rx_sr;
    logic [5:0]  r_bit_cnt;
    logic [31:0] r_rd_buf;
    logic [31:0] r_regs [128];

    logic w_sclk_s, w_csn_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_csn_rise, w_csn_fall;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_q;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_q;
    assign w_csn_rise  = w_csn_s & ~r_csn_q;
    assign w_csn_fall  = ~w_csn_s & r_csn_q;

    assign miso = r_tx_sr[39];

    // csn synchroniser resets low so a frame already running at reset release
    // cannot produce a spurious falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '1;
            r_csn_sync  <= '0;
            r_mosi_sync <= '0;
            r_sclk_q    <= 1'b1;
            r_csn_q     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], csn};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_q    <= w_sclk_s;
            r_csn_q     <= w_csn_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
            r_rd_buf  <= '0;
            miso_oe   <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < 128; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_csn_s) begin
                        r_state <= S_READY;
                    end
                end
                S_READY: begin
                    if (w_csn_fall) begin
                        r_tx_sr   <= {status_in, r_rd_buf};
                        r_bit_cnt <= '0;
                        miso_oe   <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_csn_rise) begin
                        miso_oe <= 1'b0;
                        r_state <= S_COMMIT;
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx_sr <= {r_rx_sr[38:0], w_mosi_s};
                            if (r_bit_cnt != C_SAT_CNT) begin
                                r_bit_cnt <= r_bit_cnt + 6'd1;
                            end
                        end
                        if (w_sclk_fall) begin
                            r_tx_sr <= {r_tx_sr[38:0], 1'b0};
                        end
                    end
                end
                default: begin
                    if (r_bit_cnt == C_FULL_CNT) begin
                        if (r_rx_sr[39]) begin
                            r_regs[r_rx_sr[38:32]] <= r_rx_sr[31:0];
                            wr_addr <= r_rx_sr[38:32];
                            wr_data <= r_rx_sr[31:0];
                            wr_stb  <= 1'b1;
                        end else begin
                            r_rd_buf <= r_regs[r_rx_sr[38:32]];
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                    r_state <= S_READY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tmc5130_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmc5130_spi_responder
// Purpose  : Directed self-checking bench for tmc5130_spi_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmc5130_spi_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b1;
    logic        csn = 1'b1;
    logic        mosi = 1'b0;
    logic [7:0]  status_in = 8'h00;
    logic        miso;
    logic        miso_oe;
    logic        wr_stb;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_err;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int stb_cnt = 0;
    int err_cnt = 0;

    logic [47:0] rx;

    tmc5130_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .csn       (csn),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .status_in (status_in),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb)    stb_cnt++;
        if (frame_err) err_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller enters #1 after a posedge; returns #1 after a posedge with csn
    // high for exactly the minimum gap, so frames can be issued back to back.
    // miso is sampled just before each sclk falling edge (bit 39 first).
    task automatic do_frame(input logic [47:0] data, input int nbits, input int rst_bit,
                            input logic chg_status, input logic exp_wr, input logic exp_err,
                            output logic [47:0] resp);
        logic [47:0] sh;
        sh   = data << (48 - nbits);
        resp = '0;
        csn  = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("oe_before_latency", {63'b0, miso_oe}, 64'd0);
        @(posedge clk);
        #1 chk("oe_at_latency", {63'b0, miso_oe}, 64'd1);
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
                chk("oe_after_reset", {63'b0, miso_oe}, 64'd0);
            end
            if (chg_status && i == 10) status_in = 8'h00;
            resp = {resp[46:0], miso};
            sclk = 1'b0;
            mosi = sh[47];
            sh   = sh << 1;
            repeat (4) @(posedge clk);
            #1 sclk = 1'b1;
            repeat (4) @(posedge clk);
            #1;
        end
        csn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("oe_after_frame", {63'b0, miso_oe}, 64'd0);
        chk("stb_early", {63'b0, wr_stb}, 64'd0);
        chk("ferr_early", {63'b0, frame_err}, 64'd0);
        @(posedge clk);
        #1;
        chk("stb_at_latency", {63'b0, wr_stb}, {63'b0, exp_wr});
        chk("ferr_at_latency", {63'b0, frame_err}, {63'b0, exp_err});
        @(posedge clk);
        #1;
        chk("stb_one_cycle", {63'b0, wr_stb}, 64'd0);
        chk("ferr_one_cycle", {63'b0, frame_err}, 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_miso", {63'b0, miso}, 64'd0);
        chk("rst_miso_oe", {63'b0, miso_oe}, 64'd0);
        chk("rst_wr_stb", {63'b0, wr_stb}, 64'd0);
        chk("rst_frame_err", {63'b0, frame_err}, 64'd0);
        chk("rst_wr_addr", {57'b0, wr_addr}, 64'd0);
        chk("rst_wr_data", {32'b0, wr_data}, 64'd0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Write 0x00001000 to 0x21
        status_in = 8'h3C;
        do_frame(48'h00A100001000, 40, -1, 1'b0, 1'b1, 1'b0, rx);
        chk("w21_miso", {24'b0, rx[39:0]}, 64'h3C00000000);
        chk("w21_addr", {57'b0, wr_addr}, 64'h21);
        chk("w21_data", {32'b0, wr_data}, 64'h00001000);
        chk("w21_stb_cnt", 64'(stb_cnt), 64'd1);
        chk("w21_err_cnt", 64'(err_cnt), 64'd0);

        // Read 0x21 then read 0x00: pipelined response
        repeat (6) @(posedge clk);
        #1;
        do_frame(48'h002100000000, 40, -1, 1'b0, 1'b0, 1'b0, rx);
        chk("r21_miso_old", {24'b0, rx[39:0]}, 64'h3C00000000);
        do_frame(48'h000000000000, 40, -1, 1'b0, 1'b0, 1'b0, rx);
        chk("r00_miso_21data", {24'b0, rx[39:0]}, 64'h3C00001000);

        // Short (32-bit) and long (48-bit) frames
        do_frame(48'h0000A1000055, 32, -1, 1'b0, 1'b0, 1'b1, rx);
        do_frame(48'hA1000000_55AB, 48, -1, 1'b0, 1'b0, 1'b1, rx);
        chk("bad_frames_err_cnt", 64'(err_cnt), 64'd2);
        chk("bad_frames_stb_cnt", 64'(stb_cnt), 64'd1);
        chk("bad_frames_wr_data", {32'b0, wr_data}, 64'h00001000);
        do_frame(48'h002100000000, 40, -1, 1'b0, 1'b0, 1'b0, rx);
        chk("r21_after_bad_resp", {24'b0, rx[39:0]}, 64'h3C00000000);
        do_frame(48'h000000000000, 40, -1, 1'b0, 1'b0, 1'b0, rx);
        chk("r21_unchanged", {24'b0, rx[39:0]}, 64'h3C00001000);

        // Status sampled at csn fall, changed mid-frame
        status_in = 8'h5A;
        do_frame(48'h000000000000, 40, -1, 1'b1, 1'b0, 1'b0, rx);
        chk("status_first8", {56'b0, rx[39:32]}, 64'h5A);
        chk("status_frame", {24'b0, rx[39:0]}, 64'h5A00000000);

        // Reset pulsed after 20 bits of a write frame
        status_in = 8'h3C;
        do_frame(48'h00FF12345678, 40, 20, 1'b0, 1'b0, 1'b0, rx);
        chk("rstmid_stb_cnt", 64'(stb_cnt), 64'd1);
        chk("rstmid_err_cnt", 64'(err_cnt), 64'd2);
        chk("rstmid_wr_addr", {57'b0, wr_addr}, 64'd0);
        chk("rstmid_wr_data", {32'b0, wr_data}, 64'd0);

        // Back-to-back write/read of 0x7F with minimum csn gap
        do_frame(48'h00FFFFFFFFFF, 40, -1, 1'b0, 1'b1, 1'b0, rx);
        chk("w7f_miso", {24'b0, rx[39:0]}, 64'h3C00000000);
        chk("w7f_addr", {57'b0, wr_addr}, 64'h7F);
        chk("w7f_data", {32'b0, wr_data}, 64'hFFFFFFFF);
        do_frame(48'h007F00000000, 40, -1, 1'b0, 1'b0, 1'b0, rx);
        chk("r7f_miso_old", {24'b0, rx[39:0]}, 64'h3C00000000);
        do_frame(48'h000000000000, 40, -1, 1'b0, 1'b0, 1'b0, rx);
        chk("r7f_miso_data", {24'b0, rx[39:0]}, 64'h3CFFFFFFFF);
        chk("final_stb_cnt", 64'(stb_cnt), 64'd2);
        chk("final_err_cnt", 64'(err_cnt), 64'd2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tmc5130_spi_responder.md
# tmc5130_spi_responder

Cycle-accurate SPI responder model of the TMC5130 register interface: the target-side end of the 40-bit driver datagram link that the controller drives on `sclk`/`csn`/`mosi`/`miso`. It oversamples the SPI pins in the `clk` domain and decodes write and read datagrams. It holds a 128 x 32 register file and returns the TMC5130-style pipelined read response: a status byte followed by the data requested by the previous read datagram. It is used as the driver stand-in for bench and loopback builds, and as a register-snoop port.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronisers on `sclk`, `csn` and `mosi` (minimum 2).
- `clk` input 1: system clock. Must be at least 8x the `sclk` frequency.
- `reset` input 1: asynchronous, active-high reset.
- `sclk` input 1: SPI clock, mode 3 (idles high; data sampled on rising edge, shifted on falling edge).
- `csn` input 1: active-low frame select.
- `mosi` input 1: serial data in, MSB first.
- `miso` output 1: serial data out, MSB first.
- `miso_oe` output 1: high while a frame is active. An external pad tri-states `miso` when this is low.
- `status_in` input 8: SPI_STATUS byte, sampled at frame start.
- `wr_stb` output 1: one-cycle pulse per committed write datagram.
- `wr_addr` output 7: address of the last committed write.
- `wr_data` output 32: data of the last committed write.
- `frame_err` output 1: one-cycle pulse when a frame ends with a bit count other than 40.

## Operation
- Inputs pass through `SYNC_STAGES` flip-flops. Edges are detected on the synchronised signals only.
- Datagram layout is 40 bits, MSB first:
  - bit 39: W (1 = write)
  - bits 38:32: address
  - bits 31:0: data
- States:
  - IDLE: after reset. Waits for synchronised `csn` = 1, then goes to READY. A frame already in progress at reset release is never decoded.
  - READY: on `csn` falling edge, loads `tx_sr <= {status_in, rd_buf}`, clears `bit_cnt`, sets `miso_oe` = 1 and goes to SHIFT.
  - SHIFT, `sclk` rising edge: `rx_sr <= {rx_sr[38:0], mosi}`. `bit_cnt` increments and saturates at 41.
  - SHIFT, `sclk` falling edge: `tx_sr` shifts left by one with zero fill. `miso` always equals `tx_sr[39]`.
  - SHIFT, `csn` rising edge: clears `miso_oe` and goes to COMMIT.
  - COMMIT (one cycle), `bit_cnt` = 40 and W = 1: `reg[addr] <= data`, `wr_addr`/`wr_data` updated, `wr_stb` = 1.
  - COMMIT, `bit_cnt` = 40 and W = 0: `rd_buf <= reg[addr]`. This value is returned in the next frame.
  - COMMIT, `bit_cnt` != 40: `frame_err` = 1. Register file and `rd_buf` are unchanged.
  - COMMIT always returns to READY.
- Write datagrams leave `rd_buf` unchanged.
- A read and a write to the same address in consecutive frames: the read captures the value from its own COMMIT cycle.
- `sclk` edges while `csn` is high are ignored.
- `csn` toggling with no `sclk` edges gives `bit_cnt` = 0, so `frame_err` pulses.
- Reset values:
  - `miso` = 0, `miso_oe` = 0, `wr_stb` = 0, `frame_err` = 0
  - `wr_addr` = 0, `wr_data` = 0
  - `rd_buf` = 0, every register = 0
  - state = IDLE
- Reset asserted mid-frame aborts the frame with no commit and no `frame_err`.

## Timing
- `miso`/`miso_oe` become valid exactly `SYNC_STAGES`+1 `clk` cycles after the `csn` pin falls. The first bit must be valid before the first `sclk` rising edge.
- `miso` changes `SYNC_STAGES`+1 cycles after each `sclk` pin falling edge.
- `mosi` is sampled on the synchronised rising edge. The `mosi` and `sclk` synchroniser depths are equal, so capture is aligned with the pin edge.
- `wr_stb`, `frame_err` and the `rd_buf` update occur exactly `SYNC_STAGES`+2 cycles after the `csn` pin rises.
- Minimum `csn` high time between frames is `SYNC_STAGES`+3 `clk` cycles. A shorter gap is not required to be detected.
- `wr_addr`/`wr_data` hold their values until the next committed write.

## Test plan
- Write datagram 0xA1_00001000 (W=1, addr 0x21) -> `wr_stb` pulses once, `wr_addr` = 0x21, `wr_data` = 0x00001000, `miso` stream = {`status_in`, 0x00000000}, `frame_err` = 0.
- Read 0x21 followed by a read of 0x00 -> second frame's `miso` = {`status_in`, 0x00001000}. The first read's own response carries the old `rd_buf`.
- 32-bit frame 0xA1000055 -> `frame_err` pulses, no `wr_stb`, subsequent read of 0x21 returns 0x00001000. A 48-bit frame behaves the same.
- `status_in` = 0x5A held at `csn` fall then changed to 0x00 mid-frame -> first 8 `miso` bits = 01011010.
- `reset` pulsed after 20 bits of a write frame -> no `wr_stb`, no `frame_err`, `miso_oe` = 0. The rest of that frame is ignored; the next full frame decodes normally.
- Back-to-back write then read of 0x7F (data 0xFFFFFFFF) with minimum `csn` gap and `sclk` = `clk`/8 -> correct commit. The third frame returns 0xFFFFFFFF.
